// File: rtl/regfile_pkg.sv
// Shared parameters for the RV32 integer register file.
// Default widths and the index of the hardwired-zero register.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/memory_regfile_rdport.sv
// Combinational read port for the register file.
// Selects one register from the flattened array and forces x0 to zero.
module memory_regfile_rdport
    import regfile_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_NUM_REGS = NUM_REGS
) (
    input  logic [P_ADDR_W-1:0]            addr,
    input  logic [P_NUM_REGS*P_DATA_W-1:0] regs_flat,
    output logic [P_DATA_W-1:0]            data
);

    always_comb begin
        data = '0;
        if (addr != P_ADDR_W'(ZERO_REG)) begin
            data = regs_flat[addr*P_DATA_W +: P_DATA_W];
        end
    end

endmodule

// File: rtl/memory_regfile.sv
// RV32 integer register file: 32 x 32, two async read ports, one write port.
// Asynchronous active-high reset clears every register; x0 never stores.
module memory_regfile
    import regfile_pkg::*;
#(
    parameter int P_DATA_W   = DATA_W,
    parameter int P_ADDR_W   = ADDR_W,
    parameter int P_NUM_REGS = NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [P_ADDR_W-1:0] rs1,
    input  logic [P_ADDR_W-1:0] rs2,
    input  logic [P_ADDR_W-1:0] rd,
    input  logic                reg_write,
    input  logic [P_DATA_W-1:0] write_data,
    output logic [P_DATA_W-1:0] data1,
    output logic [P_DATA_W-1:0] data2
);

    logic [P_NUM_REGS-1:0][P_DATA_W-1:0] regs;
    logic [P_NUM_REGS*P_DATA_W-1:0]      regs_flat;
    logic                                wr_en;

    assign wr_en     = reg_write && (rd != P_ADDR_W'(ZERO_REG));
    assign regs_flat = regs;

    // Slot 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[rd] <= write_data;
        end
    end

    memory_regfile_rdport #(
        .P_DATA_W  (P_DATA_W),
        .P_ADDR_W  (P_ADDR_W),
        .P_NUM_REGS(P_NUM_REGS)
    ) u_rd1 (
        .addr     (rs1),
        .regs_flat(regs_flat),
        .data     (data1)
    );

    memory_regfile_rdport #(
        .P_DATA_W  (P_DATA_W),
        .P_ADDR_W  (P_ADDR_W),
        .P_NUM_REGS(P_NUM_REGS)
    ) u_rd2 (
        .addr     (rs2),
        .regs_flat(regs_flat),
        .data     (data2)
    );

endmodule

// File: tb/tb_memory_regfile.sv
// Self-checking bench for memory_regfile.
// Directed table, corner sequences, then random traffic against an array model.
module tb_memory_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] write_data;
    logic [31:0] data1;
    logic [31:0] data2;

    int n_total;
    int n_pass;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [7];
    logic [31:0] model [32];

    memory_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .write_data(write_data),
        .data1     (data1),
        .data2     (data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        reset      = 1'b1;
        rs1        = 5'd9;
        rs2        = 5'd17;
        rd         = '0;
        reg_write  = 1'b0;
        write_data = '0;

        tbl[0] = '{5'd1,  1'b1, 32'd11,        5'd1,  5'd0,  32'd11,        32'd0};
        tbl[1] = '{5'd5,  1'b1, 32'h2A,        5'd1,  5'd5,  32'd11,        32'h2A};
        tbl[2] = '{5'd0,  1'b1, 32'd10,        5'd0,  5'd0,  32'd0,         32'd0};
        tbl[3] = '{5'd3,  1'b0, 32'd21,        5'd3,  5'd3,  32'd0,         32'd0};
        tbl[4] = '{5'd4,  1'b1, 32'd13,        5'd4,  5'd5,  32'd13,        32'h2A};
        tbl[5] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[6] = '{5'd1,  1'b1, 32'd7,         5'd1,  5'd4,  32'd7,         32'd13};

        // Reset sweep while reset is held.
        #2;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a);
            rs2 = 5'(31 - a);
            #1;
            check("reset_sweep_d1", data1, 32'd0);
            check("reset_sweep_d2", data2, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed table: write on one edge, read afterwards.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rd         = tbl[i].rd;
            reg_write  = tbl[i].we;
            write_data = tbl[i].wd;
            @(posedge clk);
            #1;
            reg_write = 1'b0;
            rs1       = tbl[i].rs1;
            rs2       = tbl[i].rs2;
            #1;
            check("table_d1", data1, tbl[i].e1);
            check("table_d2", data2, tbl[i].e2);
        end

        // Read-during-write on x4 (holds 13).
        @(negedge clk);
        rs1        = 5'd4;
        rs2        = 5'd0;
        rd         = 5'd4;
        write_data = 32'd42;
        reg_write  = 1'b1;
        #1;
        check("rdw_before", data1, 32'd13);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        check("rdw_after", data1, 32'd42);
        rs2 = 5'd4;
        #1;
        check("rdw_rs2", data2, 32'd42);

        // Mid-cycle address change follows immediately.
        rs1 = 5'd5;
        #1;
        check("addr_change", data1, 32'h2A);

        // Load x1..x7, then pulse reset between edges.
        for (int r = 1; r <= 7; r++) begin
            @(negedge clk);
            rd         = 5'(r);
            write_data = 32'(r * 32'h0101_0101);
            reg_write  = 1'b1;
        end
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        rs1       = 5'd3;
        rs2       = 5'd7;
        #1;
        check("preload_x3", data1, 32'h0303_0303);
        check("preload_x7", data2, 32'h0707_0707);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_d1", data1, 32'd0);
        check("async_rst_d2", data2, 32'd0);

        // A write edge while reset is held is blocked.
        rd         = 5'd2;
        write_data = 32'd99;
        reg_write  = 1'b1;
        rs1        = 5'd2;
        @(posedge clk);
        #1;
        check("write_blocked", data1, 32'd0);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            rs1 = 5'(r);
            rs2 = 5'(r);
            #1;
            check("post_rst_d1", data1, 32'd0);
            check("post_rst_d2", data2, 32'd0);
        end

        // Random traffic against an array model.
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rd         = 5'($urandom_range(0, 31));
            rs1        = 5'($urandom_range(0, 31));
            rs2        = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            reg_write  = ($urandom_range(0, 3) != 0);
            write_data = $urandom;
            #1;
            check("rand_d1", data1, model[rs1]);
            check("rand_d2", data2, model[rs2]);
            @(posedge clk);
            if (reg_write && rd != 0) model[rd] = write_data;
        end

        @(negedge clk);
        reg_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a);
            #1;
            check("final_sweep", data1, model[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
